// File: rtl/mc_main_controller.sv
// Multicycle MIPS main control unit: Moore FSM that sequences fetch, decode,
// execute, memory and writeback, and drives every datapath enable and select.
module mc_main_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_q;
  state_t state_d;

  logic pcwrite;
  logic branch;
  logic memwrite_raw;
  logic irwrite_raw;
  logic regwrite_raw;
  logic done_raw;
  logic illegal_raw;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state; unused encodings fall back to FETCH through the default.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LB) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    done_raw     = 1'b0;
    illegal_raw  = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = 2'b00;
    case (state_q)
      S_FETCH: begin
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        alusrcb     = 2'b01;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        alusrcb = 2'b11;
        case (op)
          OP_RTYPE, OP_LB, OP_SB, OP_ADDI, OP_BEQ, OP_J: illegal_raw = 1'b0;
          default:                                        illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
        done_raw     = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTYPEWB: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
        done_raw     = 1'b1;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      S_BEQEX: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch   = 1'b1;
        done_raw = 1'b1;
      end
      S_JEX: begin
        pcsrc    = 2'b10;
        pcwrite  = 1'b1;
        done_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked while reset is high so a mid-instruction reset never writes.
  assign pcen       = ~reset & (pcwrite | (branch & zero));
  assign memwrite   = ~reset & memwrite_raw;
  assign irwrite    = ~reset & irwrite_raw;
  assign regwrite   = ~reset & regwrite_raw;
  assign instr_done = ~reset & done_raw;
  assign illegal    = ~reset & illegal_raw;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_main_controller.sv
// Directed bench for mc_main_controller: walks LB, R-type, BEQ (taken and not),
// SB with reset in MEMWR, J and an illegal opcode, checking each cycle's decode.
module tb_mc_main_controller;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, iord, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       instr_done, illegal;
  logic [3:0] state;

  int n_cmp;
  int n_bad;

  mc_main_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_no_writes(input string tag);
    chk({tag, "_wr"}, {28'd0, pcen, memwrite, irwrite, regwrite}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    op    = 6'b000000;
    zero  = 1'b0;

    // Reset held for two edges; strobes stay low throughout.
    step();
    chk("rst1_state", state, 0);
    chk_no_writes("rst1");
    chk("rst1_done", instr_done, 0);
    step();
    chk_no_writes("rst2");
    reset = 1'b0;
    #1;

    // LB: FETCH DECODE MEMADR MEMRD MEMWB
    op = 6'b100000;
    #1;
    chk("lb1_state", state, 0);
    chk("lb1_irwrite", irwrite, 1);
    chk("lb1_pcen", pcen, 1);
    chk("lb1_aluop", aluop, 0);
    chk("lb1_alusrcb", alusrcb, 2'b01);
    chk("lb1_pcsrc", pcsrc, 0);
    chk("lb1_iord", iord, 0);
    step();
    chk("lb2_state", state, 1);
    chk("lb2_alusrcb", alusrcb, 2'b11);
    chk("lb2_aluop", aluop, 0);
    chk("lb2_illegal", illegal, 0);
    chk_no_writes("lb2");
    step();
    chk("lb3_state", state, 2);
    chk("lb3_alu", {alusrca, alusrcb, aluop}, {1'b1, 2'b10, 2'b00});
    chk_no_writes("lb3");
    step();
    chk("lb4_state", state, 3);
    chk("lb4_iord", iord, 1);
    chk_no_writes("lb4");
    step();
    chk("lb5_state", state, 4);
    chk("lb5_wb", {regwrite, memtoreg, regdst, instr_done}, 4'b1101);
    chk("lb5_memwrite", memwrite, 0);

    // R-type: next FETCH must follow at cycle 5
    step();
    op = 6'b000000;
    chk("r1_state", state, 0);
    chk("r1_done", instr_done, 0);
    step();
    chk("r2_state", state, 1);
    step();
    chk("r3_state", state, 6);
    chk("r3_alu", {alusrca, alusrcb, aluop}, {1'b1, 2'b00, 2'b10});
    chk_no_writes("r3");
    step();
    chk("r4_state", state, 7);
    chk("r4_wb", {regwrite, regdst, memtoreg, instr_done}, 4'b1101);
    step();
    chk("r5_state", state, 0);

    // BEQ taken
    op   = 6'b000100;
    zero = 1'b1;
    step();
    chk("beqt2_state", state, 1);
    step();
    chk("beqt3_state", state, 8);
    chk("beqt3_pcen", pcen, 1);
    chk("beqt3_pcsrc", pcsrc, 2'b01);
    chk("beqt3_aluop", aluop, 2'b01);
    chk("beqt3_srcs", {alusrca, alusrcb}, 3'b100);
    chk("beqt3_done", instr_done, 1);

    // BEQ not taken
    step();
    chk("beqn1_state", state, 0);
    zero = 1'b0;
    step();
    step();
    chk("beqn3_state", state, 8);
    chk("beqn3_pcen", pcen, 0);
    chk("beqn3_aluop", aluop, 2'b01);

    // SB with reset asserted in MEMWR
    step();
    op = 6'b101000;
    chk("sb1_state", state, 0);
    step();
    step();
    chk("sb3_state", state, 2);
    step();
    chk("sb4_state", state, 5);
    chk("sb4_memwrite", memwrite, 1);
    chk("sb4_iord", iord, 1);
    reset = 1'b1;
    #1;
    chk("sb4_rst_memwrite", memwrite, 0);
    chk("sb4_rst_done", instr_done, 0);
    chk("sb4_rst_iord", iord, 1);
    step();
    chk("sb_rst_state", state, 0);
    chk("sb_rst_irwrite", irwrite, 0);
    reset = 1'b0;
    #1;

    // J
    op = 6'b000010;
    chk("j1_pcen", pcen, 1);
    chk("j1_irwrite", irwrite, 1);
    step();
    step();
    chk("j3_state", state, 11);
    chk("j3_pcsrc", pcsrc, 2'b10);
    chk("j3_pcen", pcen, 1);
    chk("j3_done", instr_done, 1);
    chk("j3_regwrite", regwrite, 0);

    // Illegal opcode: pulse in DECODE, no writes, FETCH at cycle 3
    step();
    op = 6'b111111;
    chk("ill1_state", state, 0);
    step();
    chk("ill2_state", state, 1);
    chk("ill2_illegal", illegal, 1);
    chk_no_writes("ill2");
    chk("ill2_done", instr_done, 0);
    step();
    chk("ill3_state", state, 0);
    chk("ill3_illegal", illegal, 0);

    // ADDI: MEMADR-style execute, then rt writeback
    op = 6'b001000;
    step();
    step();
    chk("addi3_state", state, 9);
    chk("addi3_alu", {alusrca, alusrcb, aluop}, {1'b1, 2'b10, 2'b00});
    step();
    chk("addi4_state", state, 10);
    chk("addi4_wb", {regwrite, regdst, memtoreg, instr_done}, 4'b1001);
    step();
    chk("addi5_state", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
